// File: rtl/accel_cmd_scheduler.sv
// rtl/accel_cmd_scheduler.sv - routes front-end commands to two engines and merges their responses
module accel_cmd_scheduler #(
    parameter int ID_WIDTH        = 12,
    parameter int REQ_DATA_WIDTH  = 256,
    parameter int RESP_DATA_WIDTH = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst_b,
    input  logic                       cfg_enable,
    output logic                       sched_idle,
    input  logic                       accel_cmd_valid,
    input  logic [4:0]                 accel_cmd_opcode,
    input  logic [7:0]                 accel_cmd_hint,
    input  logic [ID_WIDTH-1:0]        accel_cmd_id,
    input  logic [31:0]                accel_cmd_insn,
    input  logic [REQ_DATA_WIDTH-1:0]  accel_cmd_data,
    output logic                       accel_cmd_ready,
    output logic [1:0]                 eng_cmd_valid,
    input  logic [1:0]                 eng_cmd_ready,
    output logic [7:0]                 eng_cmd_hint,
    output logic [ID_WIDTH-1:0]        eng_cmd_id,
    output logic [31:0]                eng_cmd_insn,
    output logic [REQ_DATA_WIDTH-1:0]  eng_cmd_data,
    input  logic [1:0]                 eng_resp_valid,
    output logic [1:0]                 eng_resp_ready,
    input  logic [ID_WIDTH-1:0]        eng0_resp_id,
    input  logic [ID_WIDTH-1:0]        eng1_resp_id,
    input  logic [RESP_DATA_WIDTH-1:0] eng0_resp_data,
    input  logic [RESP_DATA_WIDTH-1:0] eng1_resp_data,
    output logic                       accel_resp_valid,
    output logic [ID_WIDTH-1:0]        accel_resp_id,
    output logic [RESP_DATA_WIDTH-1:0] accel_resp_data,
    output logic [3:0]                 outstanding_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_OUTSTANDING);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] cnt_nxt;
    logic       rr_ptr;
    logic       tgt;
    logic       can_issue;
    logic       accept;
    logic [1:0] grant;
    logic       grant_any;
    logic       grant_idx;
    logic       unused_opcode_bits;

    // Only opcode[4] selects the engine; the remaining bits belong to the engines.
    assign tgt                = accel_cmd_opcode[4];
    assign unused_opcode_bits = ^accel_cmd_opcode[3:0];

    assign eng_cmd_hint = accel_cmd_hint;
    assign eng_cmd_id   = accel_cmd_id;
    assign eng_cmd_insn = accel_cmd_insn;
    assign eng_cmd_data = accel_cmd_data;

    assign accept = accel_cmd_valid & accel_cmd_ready;

    // Round-robin only matters on contention; a lone requester still moves the pointer.
    always_comb begin
        grant_idx = 1'b0;
        if (eng_resp_valid == 2'b11) begin
            grant_idx = rr_ptr;
        end else begin
            grant_idx = eng_resp_valid[1];
        end
    end

    assign grant_any      = |eng_resp_valid;
    assign grant          = grant_any ? (grant_idx ? 2'b10 : 2'b01) : 2'b00;
    assign eng_resp_ready = grant;

    // A spurious response at zero count is forwarded but must not underflow.
    always_comb begin
        cnt_nxt = outstanding_cnt;
        if (accept && !grant_any) begin
            cnt_nxt = outstanding_cnt + 4'd1;
        end else if (grant_any && !accept && (outstanding_cnt != 4'd0)) begin
            cnt_nxt = outstanding_cnt - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (cfg_enable) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!cfg_enable) begin
                    state_nxt = (cnt_nxt != 4'd0) ? ST_DRAIN : ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (cnt_nxt == 4'd0) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        can_issue       = (state == ST_RUN) && (outstanding_cnt < MAX_CNT);
        accel_cmd_ready = can_issue & eng_cmd_ready[tgt];
        eng_cmd_valid   = 2'b00;
        if (accel_cmd_valid && can_issue) begin
            eng_cmd_valid = tgt ? 2'b10 : 2'b01;
        end
        sched_idle = (state == ST_IDLE) && (outstanding_cnt == 4'd0);
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            outstanding_cnt <= 4'd0;
            rr_ptr          <= 1'b0;
        end else begin
            outstanding_cnt <= cnt_nxt;
            if (grant_any) begin
                rr_ptr <= ~grant_idx;
            end
        end
    end

    // Id/data hold between responses so a reader sees the last forwarded value.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            accel_resp_valid <= 1'b0;
            accel_resp_id    <= '0;
            accel_resp_data  <= '0;
        end else begin
            accel_resp_valid <= grant_any;
            if (grant_any) begin
                accel_resp_id   <= grant_idx ? eng1_resp_id : eng0_resp_id;
                accel_resp_data <= grant_idx ? eng1_resp_data : eng0_resp_data;
            end
        end
    end

endmodule

// File: tb/tb_accel_cmd_scheduler.sv
// tb/tb_accel_cmd_scheduler.sv - directed and randomized checks of accel_cmd_scheduler
module tb_accel_cmd_scheduler;

    localparam int IW   = 12;
    localparam int DW   = 256;
    localparam int RW   = 64;
    localparam int MAXO = 4;

    logic          clk = 1'b0;
    logic          rst_b;
    logic          cfg_enable;
    logic          sched_idle;
    logic          accel_cmd_valid;
    logic [4:0]    accel_cmd_opcode;
    logic [7:0]    accel_cmd_hint;
    logic [IW-1:0] accel_cmd_id;
    logic [31:0]   accel_cmd_insn;
    logic [DW-1:0] accel_cmd_data;
    logic          accel_cmd_ready;
    logic [1:0]    eng_cmd_valid;
    logic [1:0]    eng_cmd_ready;
    logic [7:0]    eng_cmd_hint;
    logic [IW-1:0] eng_cmd_id;
    logic [31:0]   eng_cmd_insn;
    logic [DW-1:0] eng_cmd_data;
    logic [1:0]    eng_resp_valid;
    logic [1:0]    eng_resp_ready;
    logic [IW-1:0] eng0_resp_id;
    logic [IW-1:0] eng1_resp_id;
    logic [RW-1:0] eng0_resp_data;
    logic [RW-1:0] eng1_resp_data;
    logic          accel_resp_valid;
    logic [IW-1:0] accel_resp_id;
    logic [RW-1:0] accel_resp_data;
    logic [3:0]    outstanding_cnt;

    always #5 clk = ~clk;

    accel_cmd_scheduler #(
        .ID_WIDTH(IW), .REQ_DATA_WIDTH(DW), .RESP_DATA_WIDTH(RW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .clk(clk), .rst_b(rst_b), .cfg_enable(cfg_enable), .sched_idle(sched_idle),
        .accel_cmd_valid(accel_cmd_valid), .accel_cmd_opcode(accel_cmd_opcode),
        .accel_cmd_hint(accel_cmd_hint), .accel_cmd_id(accel_cmd_id),
        .accel_cmd_insn(accel_cmd_insn), .accel_cmd_data(accel_cmd_data),
        .accel_cmd_ready(accel_cmd_ready), .eng_cmd_valid(eng_cmd_valid),
        .eng_cmd_ready(eng_cmd_ready), .eng_cmd_hint(eng_cmd_hint), .eng_cmd_id(eng_cmd_id),
        .eng_cmd_insn(eng_cmd_insn), .eng_cmd_data(eng_cmd_data),
        .eng_resp_valid(eng_resp_valid), .eng_resp_ready(eng_resp_ready),
        .eng0_resp_id(eng0_resp_id), .eng1_resp_id(eng1_resp_id),
        .eng0_resp_data(eng0_resp_data), .eng1_resp_data(eng1_resp_data),
        .accel_resp_valid(accel_resp_valid), .accel_resp_id(accel_resp_id),
        .accel_resp_data(accel_resp_data), .outstanding_cnt(outstanding_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 idle, 1 running, 2 draining; pref = engine favoured on contention.
    int            m_cnt;
    int            m_mode;
    int            m_pref;
    logic          exp_rv;
    logic [IW-1:0] exp_id;
    logic [RW-1:0] exp_data;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt    = 0;
        m_mode   = 0;
        m_pref   = 0;
        exp_rv   = 1'b0;
        exp_id   = '0;
        exp_data = '0;
    endtask

    task automatic set_cmd(input logic v, input logic [4:0] op, input logic [IW-1:0] id);
        accel_cmd_valid  = v;
        accel_cmd_opcode = op;
        accel_cmd_id     = id;
        accel_cmd_hint   = 8'($urandom());
        accel_cmd_insn   = $urandom();
        accel_cmd_data   = {$urandom(), $urandom(), $urandom(), $urandom(),
                            $urandom(), $urandom(), $urandom(), $urandom()};
    endtask

    task automatic set_resp(input logic [1:0] v, input logic [IW-1:0] id0, input logic [RW-1:0] d0,
                            input logic [IW-1:0] id1, input logic [RW-1:0] d1);
        eng_resp_valid = v;
        eng0_resp_id   = id0;
        eng0_resp_data = d0;
        eng1_resp_id   = id1;
        eng1_resp_data = d1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp_valid"}, accel_resp_valid, 1'b0);
        check({tag, "_resp_id"}, accel_resp_id, '0);
        check({tag, "_resp_data"}, accel_resp_data, '0);
        check({tag, "_cnt"}, outstanding_cnt, 4'd0);
        check({tag, "_idle"}, sched_idle, 1'b1);
        check({tag, "_cmd_ready"}, accel_cmd_ready, 1'b0);
        check({tag, "_cmd_valid"}, eng_cmd_valid, 2'b00);
    endtask

    // One clock: inputs were set just after a negedge; check combinational outputs,
    // advance the model at the posedge, check registered outputs at the next negedge.
    task automatic cycle();
        int         tgt;
        int         g;
        int         nxt;
        bit         can;
        bit         rdy;
        logic [1:0] ecv;
        logic [1:0] erd;
        #1;
        tgt = int'(accel_cmd_opcode[4]);
        can = (m_mode == 1) && (m_cnt < MAXO);
        rdy = can && eng_cmd_ready[tgt];
        ecv = (accel_cmd_valid && can) ? (2'b01 << tgt) : 2'b00;
        if (eng_resp_valid == 2'b11)      g = m_pref;
        else if (eng_resp_valid == 2'b01) g = 0;
        else if (eng_resp_valid == 2'b10) g = 1;
        else                              g = -1;
        erd = (g < 0) ? 2'b00 : (2'b01 << g);
        check("eng_cmd_valid", eng_cmd_valid, ecv);
        check("accel_cmd_ready", accel_cmd_ready, rdy);
        check("eng_resp_ready", eng_resp_ready, erd);
        check("eng_cmd_id", eng_cmd_id, accel_cmd_id);
        check("eng_cmd_data", eng_cmd_data, accel_cmd_data);
        @(posedge clk);
        nxt = m_cnt + ((accel_cmd_valid && rdy) ? 1 : 0) - ((g >= 0) ? 1 : 0);
        if (nxt < 0) nxt = 0;
        if (g >= 0) begin
            exp_rv   = 1'b1;
            exp_id   = (g == 1) ? eng1_resp_id : eng0_resp_id;
            exp_data = (g == 1) ? eng1_resp_data : eng0_resp_data;
            m_pref   = (g == 0) ? 1 : 0;
        end else begin
            exp_rv = 1'b0;
        end
        case (m_mode)
            0: if (cfg_enable) m_mode = 1;
            1: if (!cfg_enable) m_mode = (nxt != 0) ? 2 : 0;
            default: if (nxt == 0) m_mode = 0;
        endcase
        m_cnt = nxt;
        @(negedge clk);
        check("accel_resp_valid", accel_resp_valid, exp_rv);
        check("accel_resp_id", accel_resp_id, exp_id);
        check("accel_resp_data", accel_resp_data, exp_data);
        check("outstanding_cnt", outstanding_cnt, 4'(m_cnt));
        check("sched_idle", sched_idle, (m_mode == 0) && (m_cnt == 0));
    endtask

    task automatic do_reset();
        rst_b = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_b = 1'b1;
    endtask

    initial begin
        rst_b         = 1'b0;
        cfg_enable    = 1'b0;
        eng_cmd_ready = 2'b00;
        set_cmd(1'b0, 5'h00, '0);
        set_resp(2'b00, '0, '0, '0, '0);
        model_reset();
        #1;
        check_all_zero("reset");
        check("reset_resp_ready", eng_resp_ready, 2'b00);
        @(negedge clk);
        rst_b = 1'b1;

        // Single command to engine 0 and its response.
        cfg_enable = 1'b1;
        cycle();
        set_cmd(1'b1, 5'h03, 12'h011);
        eng_cmd_ready = 2'b01;
        cycle();
        check("t1_cnt", outstanding_cnt, 4'd1);
        set_cmd(1'b0, 5'h03, 12'h000);
        set_resp(2'b01, 12'h011, 64'hA5, 12'h000, 64'h0);
        cycle();
        check("t1_resp_id", accel_resp_id, 12'h011);
        check("t1_resp_data", accel_resp_data, 64'hA5);
        check("t1_cnt_back", outstanding_cnt, 4'd0);
        set_resp(2'b00, '0, '0, '0, '0);
        cycle();

        // Fill to the cap, then free one slot.
        eng_cmd_ready = 2'b11;
        for (int i = 0; i < MAXO; i++) begin
            set_cmd(1'b1, 5'($urandom()), 12'h100 + 12'(i));
            cycle();
        end
        check("t2_full_cnt", outstanding_cnt, 4'(MAXO));
        set_cmd(1'b1, 5'h01, 12'h1FF);
        cycle();
        check("t2_blocked_ready", accel_cmd_ready, 1'b0);
        set_resp(2'b10, 12'h0, 64'h0, 12'h100, 64'h1234);
        cycle();
        set_resp(2'b00, '0, '0, '0, '0);
        #1;
        check("t2_after_grant_ready", accel_cmd_ready, 1'b1);
        cycle();
        set_cmd(1'b0, 5'h00, '0);
        for (int i = 0; i < MAXO; i++) begin
            set_resp(2'b01, 12'h200 + 12'(i), 64'(i), 12'h0, 64'h0);
            cycle();
        end
        set_resp(2'b00, '0, '0, '0, '0);
        check("t2_drained", outstanding_cnt, 4'd0);

        // Contention right after reset alternates starting with engine 0.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_resp(2'b11, 12'hA00 + 12'(i), 64'hAA00 + 64'(i), 12'hB00 + 12'(i), 64'hBB00 + 64'(i));
            cycle();
            check("t3_alt_id", accel_resp_id, (i % 2 == 0) ? 12'hA00 + 12'(i) : 12'hB00 + 12'(i));
        end
        set_resp(2'b00, '0, '0, '0, '0);
        cycle();

        // Accept and engine-1 response in the same cycle.
        set_cmd(1'b1, 5'h10, 12'h301);
        eng_cmd_ready = 2'b10;
        cycle();
        set_cmd(1'b1, 5'h12, 12'h302);
        set_resp(2'b10, 12'h0, 64'h0, 12'h301, 64'hC0FFEE);
        cycle();
        check("t4_cnt_same", outstanding_cnt, 4'd1);
        check("t4_resp_id", accel_resp_id, 12'h301);
        set_resp(2'b00, '0, '0, '0, '0);

        // Drain with count 2.
        for (int i = 0; i < 4 && m_cnt < 2; i++) begin
            set_cmd(1'b1, 5'h10, 12'h400 + 12'(i));
            cycle();
        end
        check("t5_cnt2", outstanding_cnt, 4'd2);
        set_cmd(1'b0, 5'h10, 12'h0);
        cfg_enable = 1'b0;
        cycle();
        set_cmd(1'b1, 5'h10, 12'h4FF);
        cycle();
        check("t5_drain_ready", accel_cmd_ready, 1'b0);
        check("t5_drain_not_idle", sched_idle, 1'b0);
        cfg_enable = 1'b1;
        set_resp(2'b10, 12'h0, 64'h0, 12'h400, 64'h1);
        cycle();
        set_resp(2'b10, 12'h0, 64'h0, 12'h401, 64'h2);
        cycle();
        set_resp(2'b00, '0, '0, '0, '0);
        check("t5_idle", sched_idle, 1'b1);
        cycle();
        #1;
        check("t5_run_ready", accel_cmd_ready, 1'b1);
        set_cmd(1'b0, 5'h00, '0);
        cycle();

        // Reset while busy.
        eng_cmd_ready = 2'b11;
        for (int i = 0; i < 8 && m_cnt < MAXO; i++) begin
            set_cmd(1'b1, 5'($urandom()), 12'h500 + 12'(i));
            cycle();
        end
        set_cmd(1'b0, 5'h00, '0);
        set_resp(2'b01, 12'h5AA, 64'h55AA, 12'h0, 64'h0);
        cycle();
        check("t6_busy_cnt", outstanding_cnt, 4'd3);
        check("t6_busy_valid", accel_resp_valid, 1'b1);
        #2;
        set_resp(2'b00, '0, '0, '0, '0);
        rst_b = 1'b0;
        model_reset();
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        rst_b = 1'b1;

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 19) == 0) cfg_enable = ~cfg_enable;
            set_cmd(1'($urandom_range(0, 1)), 5'($urandom()), 12'($urandom()));
            eng_cmd_ready = 2'($urandom());
            set_resp({1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 2) == 0)},
                     12'($urandom()), {$urandom(), $urandom()},
                     12'($urandom()), {$urandom(), $urandom()});
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
